sdpram_fifo_ctrl: RTL and testbench

//  Single-clock FIFO controller that sequences the 2048x9 simple-dual-port RAM (PGL_SDPRAM_11 class) as a

---
 rtl/sdpram_fifo_pkg.sv | 20 ++
 rtl/sdpram_fifo_skid.sv | 70 +++++++
 rtl/sdpram_fifo_ctrl.sv | 140 ++++++++++++++
 tb/tb_sdpram_fifo_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdpram_fifo_pkg.sv
// Shared widths, types and helpers for the SDPRAM-backed FWFT FIFO controller.
// Optional almost-full/almost-empty flags are enabled by defining FIFO_ALMOST_FLAGS_EN.
package sdpram_fifo_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 11;
   localparam int unsigned DATA_WIDTH_DEF = 9;
   localparam int unsigned PTR_WIDTH      = ADDR_WIDTH_DEF + 1;
   localparam int unsigned LEVEL_WIDTH    = ADDR_WIDTH_DEF + 2;
   localparam int unsigned SKID_DEPTH     = 2;

   typedef logic [PTR_WIDTH-1:0]   ptr_t;
   typedef logic [LEVEL_WIDTH-1:0] level_t;
   typedef logic [1:0]             skid_cnt_t;

   // RAM depth for a given address width
   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/sdpram_fifo_skid.sv
// Two-entry output register FIFO that absorbs the RAM read latency.
// The head entry drives m_data/m_valid directly; a second entry catches a
// word returning from the RAM while the head is stalled.
module sdpram_fifo_skid
   import sdpram_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output skid_cnt_t             skid_cnt
);

   logic [DATA_WIDTH-1:0] spare_data;
   logic                  spare_valid;

   // Head/spare entry update; flush empties both but keeps the last head data visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data      <= '0;
         m_valid     <= 1'b0;
         spare_data  <= '0;
         spare_valid <= 1'b0;
      end else if (flush) begin
         m_valid     <= 1'b0;
         spare_valid <= 1'b0;
      end else begin
         unique case ({push, pop})
            2'b11: begin
               if (spare_valid) begin
                  m_data     <= spare_data;
                  spare_data <= push_data;
               end else begin
                  m_data     <= push_data;
               end
            end
            2'b01: begin
               if (spare_valid) begin
                  m_data      <= spare_data;
                  spare_valid <= 1'b0;
               end else begin
                  m_valid     <= 1'b0;
               end
            end
            2'b10: begin
               if (!m_valid) begin
                  m_data      <= push_data;
                  m_valid     <= 1'b1;
               end else begin
                  spare_data  <= push_data;
                  spare_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Occupancy reported to the read-issue logic
   always_comb begin
      skid_cnt = 2'(m_valid) + 2'(spare_valid);
   end

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// Single-clock first-word-fall-through FIFO controller for a simple-dual-port RAM.
// Owns write/read pointers, issues RAM reads ahead of the consumer and keeps
// the total word count. Define FIFO_ALMOST_FLAGS_EN to add almost_full/almost_empty.
module sdpram_fifo_ctrl
   import sdpram_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 11,
   parameter int unsigned DATA_WIDTH    = 9,
   parameter int unsigned AFULL_THRESH  = 2040,
   parameter int unsigned AEMPTY_THRESH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH+1:0] level,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic                  ram_rd_clk_en,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef FIFO_ALMOST_FLAGS_EN
   ,
   output logic                  almost_full,
   output logic                  almost_empty
`endif
);

   localparam int unsigned PTR_W = ADDR_WIDTH + 1;
   localparam int unsigned LVL_W = ADDR_WIDTH + 2;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             inflight;
   logic             flush_q;
   logic             ram_full;
   logic             ram_empty;
   logic             push;
   logic             pop;
   logic             rd_issue;
   logic [2:0]       skid_occ;
   skid_cnt_t        skid_cnt;
   logic [LVL_W-1:0] level_nxt;

   // Full/empty from the wrap bit: same low bits, MSB differs -> full
   always_comb begin
      ram_empty = (wr_ptr == rd_ptr);
      ram_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   end

   // Handshakes and read issue; a flush cycle blocks everything
   always_comb begin
      s_ready   = !rst && !flush && !flush_q && !ram_full;
      push      = s_valid && s_ready;
      pop       = m_valid && m_ready && !flush;
      skid_occ  = 3'(skid_cnt) + 3'(inflight) - 3'(pop);
      rd_issue  = !flush && !ram_empty && (skid_occ < 3'd2);
   end

   // RAM port wiring
   always_comb begin
      ram_wr_data   = s_data;
      ram_wr_addr   = wr_ptr[ADDR_WIDTH-1:0];
      ram_wr_en     = push;
      ram_rd_addr   = rd_ptr[ADDR_WIDTH-1:0];
      ram_rd_clk_en = rd_issue;
   end

   // Total words held moves only on accepted push/pop; internal moves are level-neutral
   always_comb begin
      if (flush) begin
         level_nxt = '0;
      end else begin
         level_nxt = level + LVL_W'(push) - LVL_W'(pop);
      end
   end

   // Pointers, in-flight read marker and flush history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= 1'b0;
         flush_q  <= 1'b0;
         level    <= '0;
      end else begin
         flush_q <= flush;
         level   <= level_nxt;
         if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_issue) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            inflight <= rd_issue;
         end
      end
   end

   // Output skid fed by RAM returns; a return during flush is dropped
   sdpram_fifo_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (inflight && !flush),
      .push_data (ram_rd_data),
      .pop       (pop),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .skid_cnt  (skid_cnt)
   );

`ifdef FIFO_ALMOST_FLAGS_EN
   // Threshold flags track the registered level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (level_nxt >= LVL_W'(AFULL_THRESH));
         almost_empty <= (level_nxt <= LVL_W'(AEMPTY_THRESH));
      end
   end
`endif

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Directed bench for sdpram_fifo_ctrl with a behavioural 2048x9 SDPRAM attached.
module tb_sdpram_fifo_ctrl;

   localparam int unsigned AW    = 11;
   localparam int unsigned DW    = 9;
   localparam int unsigned DEPTH = 2048;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic [AW+1:0] level;
   logic [DW-1:0] ram_wr_data;
   logic [AW-1:0] ram_wr_addr;
   logic          ram_wr_en;
   logic [AW-1:0] ram_rd_addr;
   logic          ram_rd_clk_en;
   logic [DW-1:0] ram_rd_data;
`ifdef FIFO_ALMOST_FLAGS_EN
   logic          almost_full;
   logic          almost_empty;
`endif

   sdpram_fifo_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .level         (level),
      .ram_wr_data   (ram_wr_data),
      .ram_wr_addr   (ram_wr_addr),
      .ram_wr_en     (ram_wr_en),
      .ram_rd_addr   (ram_rd_addr),
      .ram_rd_clk_en (ram_rd_clk_en),
      .ram_rd_data   (ram_rd_data)
`ifdef FIFO_ALMOST_FLAGS_EN
      ,
      .almost_full   (almost_full),
      .almost_empty  (almost_empty)
`endif
   );

   // Behavioural RAM: synchronous write, registered read with read-side reset
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
   end
   always @(posedge clk or posedge rst) begin
      if (rst) ram_rd_data <= '0;
      else if (ram_rd_clk_en) ram_rd_data <= mem[ram_rd_addr];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int            n_chk  = 0;
   int            n_pass = 0;
   int            npush  = 0;
   int            npop   = 0;
   int            nwr    = 0;
   int            dcnt   = 0;
   logic          mv_s   = 1'b0;
   logic          rdce_s = 1'b0;
   logic [DW-1:0] last_pop = '0;
   logic [DW-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One clock cycle: drive, sample before the edge, update scoreboard, step past the edge
   task automatic cyc(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
      logic psh;
      logic pp;
      logic [DW-1:0] e;
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      flush   = fl;
      #1;
      psh    = s_valid && s_ready;
      pp     = m_valid && m_ready && !fl;
      mv_s   = m_valid;
      rdce_s = ram_rd_clk_en;
      if (ram_wr_en) nwr = nwr + 1;
      if (pp) begin
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pop_data", 32'(m_data), 32'(e));
         end
         last_pop = m_data;
         npop = npop + 1;
      end
      if (psh) begin
         exp_q.push_back(sd);
         npush = npush + 1;
      end
      if (fl) exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int first_mv;
      int p0;
      rst     = 1'b1;
      flush   = 1'b0;
      s_valid = 1'b1;
      s_data  = 9'h1FF;
      m_ready = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
      chk("rst_rd_en", 32'(ram_rd_clk_en), 32'd0);
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("rst_af", 32'(almost_full), 32'd0);
      chk("rst_ae", 32'(almost_empty), 32'd1);
`endif
      rst     = 1'b0;
      s_valid = 1'b0;
      #1;
      chk("rel_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;

      // 1: five words back-to-back into an empty FIFO, first output three cycles later
      first_mv = -1;
      for (int i = 0; i < 12; i++) begin
         cyc(i < 5, 9'(i + 1), 1'b1, 1'b0);
         if (mv_s && first_mv < 0) first_mv = i;
      end
      chk("t1_latency", 32'(first_mv), 32'd3);
      chk("t1_pops", 32'(npop), 32'd5);
      chk("t1_last", 32'(last_pop), 32'h005);
      chk("t1_level", 32'(level), 32'd0);

      // 2: fill with no pops -> 2048 in RAM plus 2 in the skid
      npush = 0;
      nwr   = 0;
      for (int i = 0; i < 2060; i++) begin
         cyc(1'b1, 9'(dcnt), 1'b0, 1'b0);
         dcnt = dcnt + 1;
      end
      chk("t2_pushes", 32'(npush), 32'd2050);
      chk("t2_wr_en_cnt", 32'(nwr), 32'd2050);
      chk("t2_level", 32'(level), 32'd2050);
      chk("t2_s_ready", 32'(s_ready), 32'd0);
      chk("t2_wr_en_full", 32'(ram_wr_en), 32'd0);

      // 3: from full, push and pop every cycle across pointer wrap
      npush = 0;
      npop  = 0;
      for (int i = 0; i < 4096; i++) begin
         cyc(1'b1, 9'(dcnt), 1'b1, 1'b0);
         dcnt = dcnt + 1;
      end
      chk("t3_pushes", 32'(npush), 32'd4095);
      chk("t3_pops", 32'(npop), 32'd4096);
      chk("t3_level", 32'(level), 32'd2049);

      // 4: random push/pop, then drain; scoreboard catches loss or duplication
      npush = 0;
      for (int i = 0; i < 20000 && npush < 3000; i++) begin
         cyc(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("t4_pushes", 32'(npush), 32'd3000);
      for (int i = 0; i < 8000 && (level != 0 || m_valid); i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("t4_level", 32'(level), 32'd0);
      chk("t4_m_valid", 32'(m_valid), 32'd0);

      // Empty: m_ready ignored, m_data holds last word
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("empty_m_valid", 32'(m_valid), 32'd0);
      chk("empty_m_data", 32'(m_data), 32'(last_pop));

      // 5: flush with 100 words and a read in flight
      for (int i = 0; i < 100; i++) cyc(1'b1, 9'(i), 1'b0, 1'b0);
      chk("t5_level100", 32'(level), 32'd100);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t5_rd_issue", 32'(rdce_s), 32'd1);
      cyc(1'b1, 9'h055, 1'b1, 1'b1);
      flush   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      #1;
      chk("t5_m_valid", 32'(m_valid), 32'd0);
      chk("t5_level", 32'(level), 32'd0);
      chk("t5_s_ready", 32'(s_ready), 32'd0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b1, 9'h1AB, 1'b0, 1'b0);
      chk("t5_push_acc", 32'(exp_q.size()), 32'd1);
      p0 = npop;
      for (int i = 0; i < 10 && npop == p0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t5_first_out", 32'(last_pop), 32'h1AB);
      chk("t5_one_pop", 32'(npop - p0), 32'd1);
      chk("t5_level_end", 32'(level), 32'd0);

`ifdef FIFO_ALMOST_FLAGS_EN
      // 6: almost flags on fill and drain, then reset mid-fill
      for (int i = 0; i < 2039; i++) cyc(1'b1, 9'(i), 1'b0, 1'b0);
      chk("t6_level2039", 32'(level), 32'd2039);
      chk("t6_af_2039", 32'(almost_full), 32'd0);
      chk("t6_ae_2039", 32'(almost_empty), 32'd0);
      cyc(1'b1, 9'h0AA, 1'b0, 1'b0);
      chk("t6_af_2040", 32'(almost_full), 32'd1);
      for (int i = 0; i < 2100 && level != 9; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t6_level9", 32'(level), 32'd9);
      chk("t6_ae_9", 32'(almost_empty), 32'd0);
      chk("t6_af_9", 32'(almost_full), 32'd0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t6_level8", 32'(level), 32'd8);
      chk("t6_ae_8", 32'(almost_empty), 32'd1);
      for (int i = 0; i < 20; i++) cyc(1'b1, 9'(i), 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_af", 32'(almost_full), 32'd0);
      chk("t6_rst_ae", 32'(almost_empty), 32'd1);
      chk("t6_rst_level", 32'(level), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("t6_rel_s_ready", 32'(s_ready), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
